// File: rtl/poly_arith_pkg.sv
// Shared types and constants for the polynomial coefficient datapath.
package poly_arith_pkg;

  localparam int COEFF_W     = 12;
  localparam int Q           = 3329;
  localparam int N_COEFF_DEF = 256;

  typedef logic [COEFF_W-1:0] coeff_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mod_uni_add_sub.sv
// Two-stage modular adder/subtractor: result = (op1 +/- op2) mod Q.
module mod_uni_add_sub
  import poly_arith_pkg::*;
#(
  parameter int DATA_W = COEFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] op1_i,
  input  logic [DATA_W-1:0] op2_i,
  input  logic              is_sub_i,
  input  logic              valid_i,
  output logic [DATA_W-1:0] result_o,
  output logic              valid_o
);

  localparam int SUM_W = DATA_W + 2;
  localparam logic signed [SUM_W-1:0] Q_S = SUM_W'(Q);

  // Raw sum lies in [-(Q-1), 2Q-2]; a single conditional correction brings it into [0, Q-1].
  function automatic logic [DATA_W-1:0] mod_reduce(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] r;
    if (s[SUM_W-1])
      r = s + Q_S;
    else if (s >= Q_S)
      r = s - Q_S;
    else
      r = s;
    return DATA_W'(r);
  endfunction

  logic signed [SUM_W-1:0] op_a;
  logic signed [SUM_W-1:0] op_b;
  logic signed [SUM_W-1:0] sum_p0;
  logic                    vld_p0;
  logic [DATA_W-1:0]       res_p1;
  logic                    vld_p1;

  assign op_a = $signed({2'b00, op1_i});
  assign op_b = $signed({2'b00, op2_i});

  // Stage p0: raw signed sum or difference
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= valid_i;
    if (valid_i) sum_p0 <= is_sub_i ? (op_a - op_b) : (op_a + op_b);
  end

  // Stage p1: modular correction; result cleared on reset so the write bus idles at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      res_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) res_p1 <= mod_reduce(sum_p0);
    end
  end

  assign result_o = res_p1;
  assign valid_o  = vld_p1;

endmodule

// File: rtl/poly_addsub_engine.sv
// Streams one polynomial pair through the modular adder and writes N_COEFF results.
module poly_addsub_engine
  import poly_arith_pkg::*;
#(
  parameter int N_COEFF = N_COEFF_DEF,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              is_sub_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  coeff_t            rd_a_data_i,
  input  coeff_t            rd_b_data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output coeff_t            wr_data_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_COEFF - 1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] rd_cnt_q;
  logic              is_sub_q;
  logic              vld_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [ADDR_W-1:0] addr_p1;
  logic [ADDR_W-1:0] addr_p2;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: DRAIN waits for the last address to leave the adder pipeline
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_RUN;
      ST_RUN:   if (rd_cnt_q == LAST_ADDR) state_d = ST_DRAIN;
      ST_DRAIN: if (wr_en_o && (wr_addr_o == LAST_ADDR)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Read counter and operation latch; counter stops at the last address and only restarts on start
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      is_sub_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && start_i) begin
      rd_cnt_q <= '0;
      is_sub_q <= is_sub_i;
    end else if ((state_q == ST_RUN) && (rd_cnt_q != LAST_ADDR)) begin
      rd_cnt_q <= rd_cnt_q + 1'b1;
    end
  end

  assign rd_en_o   = (state_q == ST_RUN);
  assign rd_addr_o = rd_cnt_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE);

  // Address delay line p0..p2 tracks the memory cycle plus the two adder stages
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      addr_p0 <= '0;
      addr_p1 <= '0;
      addr_p2 <= '0;
    end else begin
      vld_p0  <= rd_en_o;
      addr_p0 <= rd_addr_o;
      addr_p1 <= addr_p0;
      addr_p2 <= addr_p1;
    end
  end

  mod_uni_add_sub #(.DATA_W(COEFF_W)) u_add_sub (
    .clk      (clk),
    .rst      (rst),
    .op1_i    (rd_a_data_i),
    .op2_i    (rd_b_data_i),
    .is_sub_i (is_sub_q),
    .valid_i  (vld_p0),
    .result_o (wr_data_o),
    .valid_o  (wr_en_o)
  );

  assign wr_addr_o = addr_p2;

endmodule
